// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: the bus between the two ALU requesters, the arbiter and the ALU.
//   Requester side : req0/req1, op0/op1, a0/b0, a1/b1 in; done0/done1, y, zero, err,
//                    busy and owner back.
//   ALU side       : alu_a, alu_b, alu_op out to the ALU; alu_y, alu_zero back.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment, which holds both requesters and the ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic [3:0]       op0;
  logic [3:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             err;
  logic             done0;
  logic             done1;
  logic             busy;
  logic             owner;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_y, alu_zero,
    output alu_a, alu_b, alu_op, y, zero, err, done0, done1, busy, owner
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_y, alu_zero,
    input  alu_a, alu_b, alu_op, y, zero, err, done0, done1, busy, owner
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for the shared ALU.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : alu_arbiter_if.slave. It carries the requests (req/op/a/b per requester),
//           the registered ALU operands (alu_a/alu_b/alu_op) and the ALU result
//           (alu_y/alu_zero). The registered responses are y/zero/err, the one-cycle
//           done0/done1 pulses, busy, and owner (the requester served now or last).
// Each operation runs IDLE -> EXEC -> DONE, so it takes three cycles. Every output is
// a register, so no input reaches an output through combinational logic.
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int NOPS  = 10
) (
  input logic           clk,
  input logic           reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit keeps the limit representable even if NOPS were 16.
  localparam logic [4:0] NOPS_L = 5'(NOPS);

  state_t state_r;
  logic   win_s;
  logic   legal_s;

  // Round-robin winner. On a tie, the requester that was not served last wins.
  always_comb begin
    win_s = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_s = ~bus.owner;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // The latched opcode is legal when it is below NOPS.
  always_comb begin
    legal_s = ({1'b0, bus.alu_op} < NOPS_L);
  end

  // Sequencer FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      bus.owner  <= 1'b1;  // requester 0 wins the first tie
      bus.alu_a  <= {WIDTH{1'b0}};
      bus.alu_b  <= {WIDTH{1'b0}};
      bus.alu_op <= 4'd0;
      bus.y      <= {WIDTH{1'b0}};
      bus.zero   <= 1'b0;
      bus.err    <= 1'b0;
      bus.done0  <= 1'b0;
      bus.done1  <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          if (bus.req0 || bus.req1) begin
            bus.owner  <= win_s;
            bus.alu_op <= win_s ? bus.op1 : bus.op0;
            bus.alu_a  <= win_s ? bus.a1  : bus.a0;
            bus.alu_b  <= win_s ? bus.b1  : bus.b0;
            bus.busy   <= 1'b1;
            state_r    <= EXEC;
          end
        end
        EXEC: begin
          // On an illegal opcode, alu_y is ignored and the result is forced to zero.
          if (legal_s) begin
            bus.y    <= bus.alu_y;
            bus.zero <= bus.alu_zero;
            bus.err  <= 1'b0;
          end else begin
            bus.y    <= {WIDTH{1'b0}};
            bus.zero <= 1'b0;
            bus.err  <= 1'b1;
          end
          bus.done0 <= ~bus.owner;
          bus.done1 <= bus.owner;
          state_r   <= DONE;
        end
        DONE: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          bus.done0 <= 1'b0;
          bus.done1 <= 1'b0;
          bus.busy  <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter. The requester drivers push the expected response
// of every request into a per-requester queue. A separate negedge monitor pops an
// entry on every done pulse, compares it, and checks the round-robin rule.
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  bit          order_q[$];
  bit          last_served;
  logic [1:0]  req_h1;
  logic [1:0]  req_h2;

  alu_arbiter_if #(.WIDTH(16)) bus();

  alu_arbiter #(.WIDTH(16), .NOPS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour. Unused opcodes return junk that the arbiter must ignore.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return ~a;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return a << 1;
      4'd8:    return a >> 1;
      4'd9:    return b;
      default: return 16'hDEAD;
    endcase
  endfunction

  assign bus.alu_y    = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_y == 16'h0000);

  // Reference response {err, zero, y}.
  function automatic logic [17:0] ref_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0] r;
    if (op >= 4'd10) return {1'b1, 1'b0, 16'h0000};
    r = alu_fn(op, a, b);
    return {1'b0, (r == 16'h0000), r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit k, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic r);
    if (k) begin
      bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.req1 = r;
    end else begin
      bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.req0 = r;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_y",     {16'h0, bus.y},      32'h0);
    check("rst_zero",  {31'h0, bus.zero},   32'h0);
    check("rst_err",   {31'h0, bus.err},    32'h0);
    check("rst_done",  {30'h0, bus.done1, bus.done0}, 32'h0);
    check("rst_busy",  {31'h0, bus.busy},   32'h0);
    check("rst_owner", {31'h0, bus.owner},  32'h1);
    check("rst_alu",   {bus.alu_a[7:0], bus.alu_b[7:0], 12'h0, bus.alu_op}, 32'h0);
    check("rst_alu_a", {16'h0, bus.alu_a},  32'h0);
  endtask

  // Single-requester operation. It also checks latency, busy release and result hold.
  task automatic do_op(input bit k, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    int n;
    bit seen;
    logic [17:0] e;
    @(posedge clk); #1;
    e = ref_model(op, a, b);
    if (k) q1.push_back(e); else q0.push_back(e);
    set_req(k, op, a, b, 1'b1);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = k ? bus.done1 : bus.done0;
    end
    if (!seen) check("done_timeout", 32'h0, 32'h1);
    else       check("latency", n, 3);
    @(posedge clk); #1;
    set_req(k, op, a, b, 1'b0);
    @(negedge clk);
    check("busy_release", {31'h0, bus.busy}, 32'h0);
    check("y_hold", {14'h0, bus.err, bus.zero, bus.y}, {14'h0, e});
  endtask

  // Concurrent requester. It re-requests back-to-back when the idle gap is 0.
  task automatic driver(input bit k, input int nops, input int max_idle, input bit fixed,
                        input logic [3:0] fop, input logic [15:0] fa, input logic [15:0] fb);
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int n;
    int idle;
    bit seen;
    @(posedge clk); #1;
    for (int i = 0; i < nops; i++) begin
      if (fixed) begin
        op = fop; a = fa; b = fb;
      end else begin
        op = 4'($urandom_range(0, 11));
        a  = 16'($urandom);
        b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      end
      if (k) q1.push_back(ref_model(op, a, b)); else q0.push_back(ref_model(op, a, b));
      set_req(k, op, a, b, 1'b1);
      n = 0; seen = 0;
      while (!seen && n < 20) begin
        @(negedge clk);
        n++;
        seen = k ? bus.done1 : bus.done0;
      end
      if (!seen) check("drv_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      idle = (max_idle == 0) ? 0 : $urandom_range(0, max_idle);
      if (idle > 0 || i == nops - 1) set_req(k, op, a, b, 1'b0);
      if (idle > 0) begin
        repeat (idle) @(posedge clk);
        #1;
      end
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse and checks round-robin.
  initial begin
    logic [17:0] e;
    bit k;
    last_served = 1'b1;
    req_h1 = 2'b00;
    req_h2 = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_served = 1'b1;
        req_h1 = 2'b00;
        req_h2 = 2'b00;
      end else begin
        if (bus.done0 && bus.done1) check("done_both", 32'h1, 32'h0);
        if (bus.done0 || bus.done1) begin
          k = bus.done1;
          order_q.push_back(k);
          check("done_owner", {31'h0, bus.owner}, {31'h0, k});
          check("done_busy", {31'h0, bus.busy}, 32'h1);
          check("winner_requested", {31'h0, req_h2[k]}, 32'h1);
          // The requests seen at the grant edge decide who should have won.
          if (req_h2 == 2'b11) check("round_robin", {31'h0, k}, {31'h0, ~last_served});
          if ((k ? q1.size() : q0.size()) == 0) begin
            check("unexpected_done", {31'h0, k}, 32'hFFFF_FFFF);
          end else begin
            e = k ? q1.pop_front() : q0.pop_front();
            check(k ? "result1" : "result0", {14'h0, bus.err, bus.zero, bus.y}, {14'h0, e});
          end
          last_served = k;
        end
        req_h2 = req_h1;
        req_h1 = {bus.req1, bus.req0};
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    set_req(1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
    set_req(1'b1, 4'd0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;

    do_op(1'b0, 4'b0010, 16'h0005, 16'h0003);
    do_op(1'b1, 4'b0011, 16'h1234, 16'h1234);
    check("owner_after_req1", {31'h0, bus.owner}, 32'h1);
    do_op(1'b0, 4'b1100, 16'h1111, 16'h2222);
    do_op(1'b0, 4'b0001, 16'h00FF, 16'h0000);
    do_op(1'b0, 4'b0010, 16'hFFFF, 16'h0001);

    // Abort an operation with reset while it is in EXEC.
    @(posedge clk); #1;
    set_req(1'b0, 4'b0010, 16'h0011, 16'h0022, 1'b1);
    @(posedge clk); #2;
    check("exec_busy", {31'h0, bus.busy}, 32'h1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    set_req(1'b0, 4'b0010, 16'h0011, 16'h0022, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    do_op(1'b0, 4'b0010, 16'h0011, 16'h0022);

    // Both requesters held continuously after a fresh reset: 0,1,0,1...
    pulse_reset();
    order_q.delete();
    fork
      driver(1'b0, 6, 0, 1'b1, 4'b0000, 16'hAAAA, 16'h0000);
      driver(1'b1, 6, 0, 1'b1, 4'b1001, 16'h0000, 16'h5555);
    join
    check("alt_count", order_q.size(), 12);
    for (int i = 0; i < order_q.size(); i++) begin
      check("alternation", {31'h0, order_q[i]}, i % 2);
    end

    // Randomized traffic from both requesters.
    fork
      driver(1'b0, 40, 3, 1'b0, 4'd0, 16'h0, 16'h0);
      driver(1'b1, 40, 3, 1'b0, 4'd0, 16'h0, 16'h0);
    join
    repeat (4) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 16-bit ALU in the extended CPU. The CPU datapath (requester 0) and the coprocessor/debug port (requester 1) each post one operation at a time as an opcode plus two operands. The block grants one requester, drives the ALU from registered operands, captures the result and zero flag, and returns them with a one-cycle done pulse. It sits between the requesters and the ALU instance and owns every ALU input.

## Interface
- WIDTH, 16, data width of operands, result and ALU ports
- NOPS, 10, number of legal opcodes (0..NOPS-1); opcodes ≥ NOPS are illegal

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  operation request; held high until that requester's done pulse
- op0 / op1  in  4  opcode in ALU encoding; stable while req high
- a0, b0 / a1, b1  in  WIDTH  operands; stable while req high
- alu_a, alu_b  out  WIDTH  to ALU a, b (registered)
- alu_op  out  4  to ALU op_alu (registered)
- alu_y  in  WIDTH  from ALU y
- alu_zero  in  1  from ALU zero
- y  out  WIDTH  registered result, valid while done0 or done1 is high
- zero  out  1  registered zero flag, valid with done
- err  out  1  illegal-opcode flag, valid with done
- done0 / done1  out  1  one-cycle completion pulse to the owning requester
- busy  out  1  high in EXEC and DONE
- owner  out  1  requester currently or last served

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state is IDLE.
- IDLE, no request: hold all registers.
- IDLE with any req high:
  - Pick the winner. If only one requester is high, it wins. If both are high, the requester that is not `owner` wins.
  - Latch the winner's op, a and b into alu_op, alu_a and alu_b. Set `owner` to the winner.
  - Go to EXEC.
- EXEC, legal op (op < NOPS):
  - The ALU evaluates combinationally from the registers.
  - At the end of the cycle: y ← alu_y, zero ← alu_zero, err ← 0.
  - Go to DONE.
- EXEC, illegal op: y ← 0, zero ← 0, err ← 1; alu_y is ignored. Go to DONE.
- DONE: assert done[owner] only. Then go to IDLE.
- Requests are sampled only in IDLE. Requests in EXEC or DONE wait.
- Requester rule: deassert req on the clock edge at which it samples done=1.
  - A req still high in the following IDLE cycle is a new request.
  - Under the round-robin rule, that new request loses to the other requester if both are high.
- y, zero and err hold their values after DONE until the next EXEC completes.
- alu_a, alu_b and alu_op hold the last latched values; they are not cleared after an operation.
- Width rule: WIDTH-bit modular arithmetic, as computed by the ALU. The block does no arithmetic of its own.

## Timing
- Reset values (asynchronous, immediate on reset low):
  - state IDLE, owner 1 (requester 0 wins the first tie)
  - alu_a = alu_b = 0, alu_op = 0
  - y = 0, zero = 0, err = 0
  - done0 = done1 = 0, busy = 0
- Latency: req sampled high at IDLE edge T → done high in cycle T+2.
- Throughput: one operation per 3 cycles when requests are back-to-back.
- done, y, zero, err and busy are all registered outputs; there is no combinational path from any input to any output.
- Reset during EXEC or DONE: the operation is aborted and no done pulse is issued. The requester re-requests after reset release.
- Both requesters high in every IDLE cycle: grants strictly alternate 0,1,0,1…

## Test plan
- Reset, then req0=1, op0=4'b0010, a0=16'h0005, b0=16'h0003 → done0 in 3rd cycle after the request edge, y=16'h0008, zero=0, err=0, done1 never high.
- req1 only, op1=4'b0011, a1=b1=16'h1234 → done1, y=16'h0000, zero=1; owner=1.
- Both requesters held continuously, each re-requesting after done (op0=4'b0000 a0=16'hAAAA; op1=4'b1001 b1=16'h5555) → first grant to 0 after reset, then strictly alternating done0/done1 every 3 cycles with y=AAAA/5555.
- req0 with op0=4'b1100 → done0 with err=1, y=0, zero=0; a following legal op0=4'b0001, a0=16'h00FF gives y=16'hFF00, err=0.
- Reset driven low during EXEC of a req0 op → no done pulse; all outputs return to reset values immediately; the request re-issued after release completes normally.
- Add wrap case: op0=4'b0010, a0=16'hFFFF, b0=16'h0001 → y=16'h0000, zero=1.
